instr_issue_unit: RTL and testbench

- Producer end of the 32-bit instruction interface that feeds the execute stage.
- Holds a small program buffer that is loaded over a write port, then streams the stored words in order under a valid/ready handshake.
- Replaces free-running per-period instruction drive with a flow-controlled source, so execute can stall the stream.

---
 rtl/instr_issue_pkg.sv | 22 ++
 rtl/instr_issue_if.sv | 13 +
 rtl/instr_issue_unit_prog_buf.sv | 29 ++
 rtl/instr_issue_unit.sv | 171 +++++++++++++++++
 tb/tb_instr_issue_unit.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_issue_pkg.sv
// rtl/instr_issue_pkg.sv - shared types and constants for the instruction issue unit
package instr_issue_pkg;

  localparam int IW_DEF    = 32;
  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  // Handshake outcome names: a word either transfers this cycle or is held
  localparam logic HS_FIRE = 1'b1;
  localparam logic HS_HOLD = 1'b0;

  function automatic logic handshake(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/instr_issue_if.sv
// rtl/instr_issue_if.sv - valid/ready instruction stream toward the execute stage
interface instr_issue_if
  import instr_issue_pkg::*;
#(
  parameter int IW = IW_DEF
);
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/instr_issue_unit_prog_buf.sv
// rtl/instr_issue_unit_prog_buf.sv - program buffer, synchronous write and combinational read
module prog_buf
  import instr_issue_pkg::*;
#(
  parameter int IW    = IW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [IW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [IW-1:0] rd_data
);

  // Contents are deliberately left unreset; software loads them before start
  logic [IW-1:0] mem_q [DEPTH];

  // Write port: one word per clock when enabled
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/instr_issue_unit.sv
// rtl/instr_issue_unit.sv - flow-controlled instruction source; optional INSTR_ISSUE_REPEAT_EN loops the program
module instr_issue_unit
  import instr_issue_pkg::*;
#(
  parameter int IW    = IW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          abort,
`ifdef INSTR_ISSUE_REPEAT_EN
  input  logic          repeat_en,
`endif
  instr_issue_if.master iss,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          len_err
);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          len_err_q, len_err_d;

  logic          hs;
  logic          last_hs;
  logic          rpt;
  logic          len_bad;
  logic          wr_en;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data;

`ifdef INSTR_ISSUE_REPEAT_EN
  assign rpt = repeat_en;
`else
  assign rpt = 1'b0;
`endif

  assign hs      = handshake(valid_q, iss.instr_ready) && (state_q == ISSUE);
  assign last_hs = hs && ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
  assign len_bad = (prog_len == '0) || (prog_len > (AW+1)'(DEPTH));
  assign wr_en   = load_en && (state_q == IDLE) && !abort;

  // Read address tracks the word that will be presented after this edge
  always_comb begin
    rd_addr = pc_q;
    if (hs == HS_FIRE) begin
      rd_addr = last_hs ? '0 : pc_q + AW'(1);
    end
  end

  prog_buf #(
    .IW    (IW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Next-state and output computation; abort overrides everything at the end
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    len_d     = len_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    len_err_d = len_err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_bad) begin
            len_err_d = 1'b1;
          end else begin
            len_d   = prog_len;
            pc_d    = '0;
            state_d = FETCH;
          end
        end
      end

      FETCH: begin
        instr_d = rd_data;
        valid_d = 1'b1;
        state_d = ISSUE;
      end

      ISSUE: begin
        if (hs == HS_FIRE) begin
          if (last_hs) begin
            done_d = 1'b1;
            pc_d   = '0;
            if (rpt) begin
              // Wrap straight back to word 0 with no bubble
              instr_d = rd_data;
            end else begin
              instr_d = '0;
              valid_d = 1'b0;
              state_d = IDLE;
            end
          end else begin
            pc_d    = pc_q + AW'(1);
            instr_d = rd_data;
          end
        end
      end

      default: begin
        state_d = IDLE;
        pc_d    = '0;
        instr_d = '0;
        valid_d = 1'b0;
      end
    endcase

    if (abort) begin
      state_d   = IDLE;
      pc_d      = '0;
      instr_d   = '0;
      valid_d   = 1'b0;
      done_d    = 1'b0;
      len_d     = len_q;
      len_err_d = len_err_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      len_q     <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      len_q     <= len_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      len_err_q <= len_err_d;
    end
  end

  assign iss.instr       = instr_q;
  assign iss.instr_valid = valid_q;
  assign pc              = pc_q;
  assign busy            = (state_q == FETCH) || (state_q == ISSUE);
  assign done            = done_q;
  assign len_err         = len_err_q;

endmodule

// File: tb/tb_instr_issue_unit.sv
// tb/tb_instr_issue_unit.sv - directed self-checking bench for instr_issue_unit
module tb_instr_issue_unit;

  localparam int IW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [IW-1:0] load_data = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
`ifdef INSTR_ISSUE_REPEAT_EN
  logic          repeat_en = 1'b0;
`endif
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;
  logic          len_err;

  int checks = 0;
  int failures = 0;

  logic [IW-1:0] prog [DEPTH];

  instr_issue_if #(.IW(IW)) iss ();

  always #5 clk = ~clk;

  instr_issue_unit #(
    .IW    (IW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .prog_len  (prog_len),
    .start     (start),
    .abort     (abort),
`ifdef INSTR_ISSUE_REPEAT_EN
    .repeat_en (repeat_en),
`endif
    .iss       (iss),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .len_err   (len_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (iss.instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", iss.instr); end
    checks++; if (iss.instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", iss.instr_valid); end
    checks++; if (pc !== 4'd0) begin failures++; $display("FAIL rst_pc got=%0d exp=0", pc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL rst_len_err got=%b exp=0", len_err); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load();
    for (int i = 0; i < DEPTH; i++) begin
      load_en   = 1'b1;
      load_addr = AW'(i);
      load_data = prog[i];
      tick();
    end
    load_en = 1'b0;
  endtask

  task automatic test_basic();
    iss.instr_ready = 1'b1;
    prog_len = 5'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || iss.instr_valid !== 1'b0) begin failures++; $display("FAIL basic_fetch got busy=%b valid=%b exp busy=1 valid=0", busy, iss.instr_valid); end
    tick();
    checks++; if (iss.instr_valid !== 1'b1 || iss.instr !== prog[0] || pc !== 4'd0) begin failures++; $display("FAIL basic_w0 got v=%b i=%h pc=%0d exp v=1 i=%h pc=0", iss.instr_valid, iss.instr, pc, prog[0]); end
    tick();
    checks++; if (iss.instr_valid !== 1'b1 || iss.instr !== prog[1] || pc !== 4'd1) begin failures++; $display("FAIL basic_w1 got v=%b i=%h pc=%0d exp v=1 i=%h pc=1", iss.instr_valid, iss.instr, pc, prog[1]); end
    tick();
    checks++; if (iss.instr_valid !== 1'b1 || iss.instr !== prog[2] || pc !== 4'd2) begin failures++; $display("FAIL basic_w2 got v=%b i=%h pc=%0d exp v=1 i=%h pc=2", iss.instr_valid, iss.instr, pc, prog[2]); end
    tick();
    checks++; if (iss.instr_valid !== 1'b0 || done !== 1'b1 || pc !== 4'd0 || busy !== 1'b0) begin failures++; $display("FAIL basic_end got v=%b done=%b pc=%0d busy=%b exp v=0 done=1 pc=0 busy=0", iss.instr_valid, done, pc, busy); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_stall();
    iss.instr_ready = 1'b1;
    prog_len = 5'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    iss.instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        start = 1'b1;
        load_en = 1'b1;
        load_addr = 4'd2;
        load_data = 32'hDEAD_BEEF;
      end
      tick();
      start = 1'b0;
      load_en = 1'b0;
      checks++; if (iss.instr_valid !== 1'b1 || iss.instr !== prog[1] || pc !== 4'd1) begin failures++; $display("FAIL stall_hold%0d got v=%b i=%h pc=%0d exp v=1 i=%h pc=1", i, iss.instr_valid, iss.instr, pc, prog[1]); end
    end
    iss.instr_ready = 1'b1;
    tick();
    checks++; if (iss.instr_valid !== 1'b1 || iss.instr !== prog[2] || pc !== 4'd2) begin failures++; $display("FAIL stall_w2 got v=%b i=%h pc=%0d exp v=1 i=%h pc=2", iss.instr_valid, iss.instr, pc, prog[2]); end
    tick();
    checks++; if (done !== 1'b1 || iss.instr_valid !== 1'b0) begin failures++; $display("FAIL stall_done got done=%b v=%b exp done=1 v=0", done, iss.instr_valid); end
    tick();
  endtask

  task automatic test_reset_mid();
    iss.instr_ready = 1'b1;
    prog_len = 5'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    iss.instr_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (iss.instr_valid !== 1'b0 || iss.instr !== 32'h0 || pc !== 4'd0 || busy !== 1'b0) begin failures++; $display("FAIL async_reset got v=%b i=%h pc=%0d busy=%b exp all 0", iss.instr_valid, iss.instr, pc, busy); end
    tick();
    reset = 1'b1;
    tick();
    iss.instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (iss.instr_valid !== 1'b1 || iss.instr !== prog[0] || pc !== 4'd0) begin failures++; $display("FAIL replay_w0 got v=%b i=%h pc=%0d exp v=1 i=%h pc=0", iss.instr_valid, iss.instr, pc, prog[0]); end
    tick();
    checks++; if (iss.instr !== prog[1]) begin failures++; $display("FAIL replay_w1 got=%h exp=%h", iss.instr, prog[1]); end
    tick();
    tick();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL replay_done got=%b exp=1", done); end
    tick();
  endtask

  task automatic test_abort();
    iss.instr_ready = 1'b1;
    prog_len = 5'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (iss.instr_valid !== 1'b0 || busy !== 1'b0 || pc !== 4'd0 || done !== 1'b0) begin failures++; $display("FAIL abort_now got v=%b busy=%b pc=%0d done=%b exp 0", iss.instr_valid, busy, pc, done); end
    tick();
    checks++; if (iss.instr_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_after got v=%b done=%b exp 0", iss.instr_valid, done); end
  endtask

  task automatic test_len_err();
    prog_len = 5'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (len_err !== 1'b1 || busy !== 1'b0 || iss.instr_valid !== 1'b0) begin failures++; $display("FAIL len0 got err=%b busy=%b v=%b exp err=1 busy=0 v=0", len_err, busy, iss.instr_valid); end
    tick();
    checks++; if (busy !== 1'b0 || iss.instr_valid !== 1'b0) begin failures++; $display("FAIL len0_idle got busy=%b v=%b exp 0", busy, iss.instr_valid); end
    prog_len = 5'd17;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (len_err !== 1'b1 || busy !== 1'b0 || iss.instr_valid !== 1'b0) begin failures++; $display("FAIL len17 got err=%b busy=%b v=%b exp err=1 busy=0 v=0", len_err, busy, iss.instr_valid); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (len_err !== 1'b0) begin failures++; $display("FAIL len_err_clear got=%b exp=0", len_err); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_full16();
    int n;
    int dcnt;
    bit finished;
    n = 0;
    dcnt = 0;
    finished = 1'b0;
    iss.instr_ready = 1'b1;
    prog_len = 5'd16;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int c = 0; c < 40 && !finished; c++) begin
      if (iss.instr_valid === 1'b1) begin
        checks++;
        if (n >= DEPTH) begin
          failures++; $display("FAIL full_extra got word %0d exp at most 16", n);
        end else if (iss.instr !== prog[n] || pc !== AW'(n)) begin
          failures++; $display("FAIL full_w%0d got i=%h pc=%0d exp i=%h pc=%0d", n, iss.instr, pc, prog[n], n);
        end
        n++;
      end else if (busy === 1'b1) begin
        checks++; failures++; $display("FAIL full_bubble got valid=0 exp valid=1 at word %0d", n);
      end
      tick();
      if (done === 1'b1) dcnt++;
      if (busy === 1'b0) finished = 1'b1;
    end
    checks++; if (!finished) begin failures++; $display("FAIL full_timeout got busy=%b exp busy=0", busy); end
    checks++; if (n != 16) begin failures++; $display("FAIL full_count got=%0d exp=16", n); end
    checks++; if (dcnt != 1) begin failures++; $display("FAIL full_done got=%0d exp=1", dcnt); end
    checks++; if (pc !== 4'd0 || iss.instr_valid !== 1'b0) begin failures++; $display("FAIL full_end got pc=%0d v=%b exp pc=0 v=0", pc, iss.instr_valid); end
    tick();
  endtask

`ifdef INSTR_ISSUE_REPEAT_EN
  task automatic test_repeat();
    int dcnt;
    dcnt = 0;
    repeat_en = 1'b1;
    iss.instr_ready = 1'b1;
    prog_len = 5'd16;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (iss.instr_valid !== 1'b1 || iss.instr !== prog[k % 16] || pc !== AW'(k % 16)) begin
        failures++; $display("FAIL rep_w%0d got v=%b i=%h pc=%0d exp v=1 i=%h pc=%0d", k, iss.instr_valid, iss.instr, pc, prog[k % 16], k % 16);
      end
      tick();
      if (done === 1'b1) dcnt++;
    end
    checks++; if (dcnt != 2) begin failures++; $display("FAIL rep_done got=%0d exp=2", dcnt); end
    abort = 1'b1;
    repeat_en = 1'b0;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || iss.instr_valid !== 1'b0) begin failures++; $display("FAIL rep_abort got busy=%b done=%b v=%b exp 0", busy, done, iss.instr_valid); end
    tick();
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

  initial begin
    iss.instr_ready = 1'b0;
    prog[0] = 32'h8000_0000;
    prog[1] = 32'h8000_0010;
    prog[2] = 32'h0040_0010;
    for (int i = 3; i < DEPTH; i++) prog[i] = 32'hA500_0000 | (i * 32'h0001_0101);
    test_reset();
    test_load();
    test_basic();
    test_stall();
    test_reset_mid();
    test_abort();
    test_len_err();
    test_full16();
`ifdef INSTR_ISSUE_REPEAT_EN
    test_repeat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
